dpram_fifo_ctrl: RTL and testbench

FIFO controller that sits directly upstream of the dual-port RAM and drives its write and read ports. It turns push/pop requests into RAM write/read strobes and addresses, and tracks occupancy with full/empty/count. It also generates a data-valid strobe aligned with the RAM's registered read data. Together with the RAM, it forms a synchronous 16-entry × 8-bit FIFO.

---
 rtl/dpram_fifo_ctrl_if.sv | 48 ++++
 rtl/dpram_fifo_ctrl.sv | 87 ++++++++
 tb/tb_dpram_fifo_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_if.sv
// Bundle between a FIFO user, the dpram_fifo_ctrl controller and the dual-port RAM ports.
// Sticky error signals exist only when DPRAM_FIFO_ERR_FLAGS_EN is defined.
interface dpram_fifo_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // push/pop are requests qualified by full/empty as sampled in the same cycle:
    // a request is taken at the next rising edge only if the matching flag is low.
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              wr_enb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_enb;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data_vld;
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    modport master (
        output push, push_data, pop, err_clr,
        input  full, empty, count, wr_enb, wr_addr, wr_data,
        input  rd_enb, rd_addr, rd_data_vld, overflow, underflow
    );
    modport slave (
        input  push, push_data, pop, err_clr,
        output full, empty, count, wr_enb, wr_addr, wr_data,
        output rd_enb, rd_addr, rd_data_vld, overflow, underflow
    );
`else
    modport master (
        output push, push_data, pop,
        input  full, empty, count, wr_enb, wr_addr, wr_data,
        input  rd_enb, rd_addr, rd_data_vld
    );
    modport slave (
        input  push, push_data, pop,
        output full, empty, count, wr_enb, wr_addr, wr_data,
        output rd_enb, rd_addr, rd_data_vld
    );
`endif
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: pointers, occupancy flags and read-valid strobe.
// Optional sticky overflow/underflow flags are built when DPRAM_FIFO_ERR_FLAGS_EN is defined.
module dpram_fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic             clk,
    input logic             rst,
    dpram_fifo_ctrl_if.slave bus
);
    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             vld_q;
    logic             push_acc;
    logic             pop_acc;
    logic             full_nxt;
    logic             empty_nxt;

    // Acceptance uses the registered flags, so a full FIFO never writes the slot being read.
    always_comb begin
        push_acc   = bus.push & ~full_q;
        pop_acc    = bus.pop & ~empty_q;
        wr_ptr_nxt = wr_ptr + PTR_W'(push_acc);
        rd_ptr_nxt = rd_ptr + PTR_W'(pop_acc);
        count_nxt  = count_q + PTR_W'(push_acc) - PTR_W'(pop_acc);
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                     (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            full_q  <= full_nxt;
            empty_q <= empty_nxt;
            vld_q   <= pop_acc;
        end
    end

    // Strobes are gated by reset so the RAM sees no access while the controller is cleared.
    assign bus.wr_enb      = push_acc & rst;
    assign bus.wr_addr     = wr_ptr[ADDR_W-1:0];
    assign bus.wr_data     = DATA_W'(bus.push_data);
    assign bus.rd_enb      = pop_acc & rst;
    assign bus.rd_addr     = rd_ptr[ADDR_W-1:0];
    assign bus.rd_data_vld = vld_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = count_q;

`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    // A new error in the same cycle as err_clr wins, so no event is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~bus.err_clr) | (bus.push & full_q);
            unf_q <= (unf_q & ~bus.err_clr) | (bus.pop & empty_q);
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a RAM model; checks against a queue-based FIFO reference.
// Build with DPRAM_FIFO_ERR_FLAGS_EN defined to also cover the sticky error flags.
module tb_dpram_fifo_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;

    dpram_fifo_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dpram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Dual-port RAM with registered read data; contents survive reset.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    always @(posedge clk) begin
        if (bus.wr_enb) mem[bus.wr_addr] <= bus.wr_data;
        if (bus.rd_enb) rd_data <= mem[bus.rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    int                m_wr_addr;
    int                m_rd_addr;
    logic              m_vld;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_ovf;
    logic              m_unf;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_wr_addr = 0;
        m_rd_addr = 0;
        m_vld     = 1'b0;
        m_rd_data = '0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
    endtask

    task automatic check_regs();
        check("full",  bus.full,  exp_q.size() == DEPTH);
        check("empty", bus.empty, exp_q.size() == 0);
        check("count", bus.count, exp_q.size());
        check("rd_data_vld", bus.rd_data_vld, m_vld);
        if (m_vld) check("rd_data", rd_data, m_rd_data);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        check("overflow",  bus.overflow,  m_ovf);
        check("underflow", bus.underflow, m_unf);
`endif
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model past the rising edge.
    task automatic cyc(input logic p, input logic [DATA_W-1:0] d, input logic o, input logic c);
        logic pacc;
        logic oacc;
        logic was_full;
        logic was_empty;
        @(negedge clk);
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = o;
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        bus.err_clr   = c;
`endif
        #1;
        check_regs();
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        pacc = p && !was_full;
        oacc = o && !was_empty;
        check("wr_enb", bus.wr_enb, pacc);
        check("rd_enb", bus.rd_enb, oacc);
        if (pacc) begin
            check("wr_addr", bus.wr_addr, m_wr_addr);
            check("wr_data", bus.wr_data, d);
        end
        if (oacc) check("rd_addr", bus.rd_addr, m_rd_addr);
        @(posedge clk);
        if (oacc) begin
            m_rd_data = exp_q.pop_front();
            m_rd_addr = (m_rd_addr + 1) % DEPTH;
        end
        if (pacc) begin
            exp_q.push_back(d);
            m_wr_addr = (m_wr_addr + 1) % DEPTH;
        end
        m_vld = oacc;
        m_ovf = (m_ovf && !c) || (p && was_full);
        m_unf = (m_unf && !c) || (o && was_empty);
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_enb", bus.wr_enb, 1'b0);
        check("rst_rd_enb", bus.rd_enb, 1'b0);
        check_regs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst           = 1'b0;
        bus.push      = 1'b1;
        bus.push_data = '0;
        bus.pop       = 1'b1;
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        bus.err_clr   = 1'b0;
`endif

        // Reset with requests held high: strobes must stay low.
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

        // Pop on empty
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Fill with 0x10..0x1F
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DATA_W'(8'h10 + i), 1'b0, 1'b0);

        // Push on full, then clear the sticky flag
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Simultaneous at full: only the pop is taken
        cyc(1'b1, 8'h55, 1'b1, 1'b0);

        // Drain, then simultaneous at empty: only the push is taken
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 8'h66, 1'b1, 1'b0);

        // Bring occupancy to 5 and do a simultaneous push/pop
        for (int i = 0; i < 4; i++) cyc(1'b1, DATA_W'(8'h70 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);

        // Hold occupancy at 3 across 40 push/pop pairs so addresses wrap
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, DATA_W'($urandom), 1'b1, 1'b0);

        // Error flag set coinciding with err_clr keeps the flag
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 3) != 0), DATA_W'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));

        // Mid-burst reset while a read-valid strobe is in flight
        for (int i = 0; i < 4; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        #2;
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        rst      = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst      = 1'b1;

        // Traffic after reset
        for (int i = 0; i < 6; i++) cyc(1'b1, DATA_W'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
